// File: rtl/crypto_pkg.sv
// -----------------------------------------------------------------------------
// crypto_pkg
// Shared types and helpers for crypto_stream_unit and its keystream generator.
//   state_e        : FSM states (IDLE, READ, CALC, WRITE, FIN)
//   DEF_*          : default word width, LFSR feedback mask and rotate amount
//   MODE_ENC/DEC   : values of the mode input
//   rotl / rotr    : width-generic rotations on a 64-bit carrier word
// -----------------------------------------------------------------------------
package crypto_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CALC,
    ST_WRITE,
    ST_FIN
  } state_e;

  localparam int DEF_DATA_W = 19;
  localparam logic [DEF_DATA_W-1:0] DEF_LFSR_TAPS = 19'h72000;
  localparam int DEF_ROT = 3;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Rotations operate on the low w bits of a wide carrier so that one pair of
  // functions serves any DATA_W up to ROT_MAX_W. With constant w and n they
  // reduce to plain wiring.
  localparam int ROT_MAX_W = 64;
  typedef logic [ROT_MAX_W-1:0] rot_word_t;

  function automatic rot_word_t width_mask(input int unsigned w);
    rot_word_t m;
    if (w >= ROT_MAX_W) m = '1;
    else                m = (rot_word_t'(1) << w) - rot_word_t'(1);
    return m;
  endfunction

  function automatic rot_word_t rotl(input rot_word_t x, input int unsigned w,
                                     input int unsigned n);
    rot_word_t   m;
    rot_word_t   v;
    rot_word_t   r;
    int unsigned s;
    m = width_mask(w);
    v = x & m;
    s = n % w;
    if (s == 0) r = v;
    else        r = ((v << s) | (v >> (w - s))) & m;
    return r;
  endfunction

  function automatic rot_word_t rotr(input rot_word_t x, input int unsigned w,
                                     input int unsigned n);
    rot_word_t   m;
    rot_word_t   v;
    rot_word_t   r;
    int unsigned s;
    m = width_mask(w);
    v = x & m;
    s = n % w;
    if (s == 0) r = v;
    else        r = ((v >> s) | (v << (w - s))) & m;
    return r;
  endfunction

endpackage

// File: rtl/crypto_stream_unit_if.sv
// -----------------------------------------------------------------------------
// crypto_stream_unit_if
// SoC data-memory port: combinational read, write captured at posedge.
//   mem_addr     : word address (master -> memory)
//   mem_write    : write strobe (master -> memory)
//   mem_data_out : write data   (master -> memory)
//   mem_data_in  : read data for the current mem_addr (memory -> master)
// -----------------------------------------------------------------------------
interface crypto_stream_unit_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;

  modport master (output mem_addr, output mem_write, output mem_data_out,
                  input  mem_data_in);
  modport slave  (input  mem_addr, input  mem_write, input  mem_data_out,
                  output mem_data_in);
endinterface

// File: rtl/crypto_keystream.sv
// -----------------------------------------------------------------------------
// crypto_keystream
// Galois LFSR keystream generator.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load seed (a zero seed is replaced by 1 so the LFSR never locks)
//   advance   : step the LFSR once
//   seed      : value loaded on load
//   ks        : current keystream word
// -----------------------------------------------------------------------------
module crypto_keystream
  import crypto_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] ks
);

  logic [DATA_W-1:0] ks_q;
  logic [DATA_W-1:0] ks_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ks_d = ks_q;
    if (load) begin
      ks_d = (seed == '0) ? DATA_W'(1) : seed;
    end else if (advance) begin
      ks_d = (ks_q >> 1) ^ (ks_q[0] ? LFSR_TAPS : '0);
    end
  end

  // NOTE: all flops, datapath included, clear on reset so every output reads 0 as soon as rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ks_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so all flops update together from pre-edge values.
      ks_q <= ks_d;
    end
  end

  assign ks = ks_q;

endmodule

// File: rtl/crypto_stream_unit.sv
// -----------------------------------------------------------------------------
// crypto_stream_unit
// Reads `length` words from input_addr, encrypts/decrypts each with an LFSR
// keystream plus a fixed rotation, writes results to result_addr, then pulses
// done. Three cycles per word (READ, CALC, WRITE).
//   clk, rst      : clock, asynchronous active-low reset
//   start         : one-cycle request, accepted only in IDLE
//   mode          : MODE_ENC / MODE_DEC, latched at start
//   key           : LFSR seed, latched at start
//   input_addr    : source base, latched at start
//   result_addr   : destination base, latched at start
//   length        : word count, latched at start
//   mem           : memory port (master side of crypto_stream_unit_if)
//   busy          : high in every state except IDLE
//   done          : one-cycle pulse, the cycle after FIN
// Build option: define CRYPTO_CHAIN_EN for block chaining (previous ciphertext
// word is folded into each result).
// -----------------------------------------------------------------------------
module crypto_stream_unit
  import crypto_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = 10,
  parameter int                ROT       = DEF_ROT,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] key,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [ADDR_W-1:0] result_addr,
  input  logic [ADDR_W-1:0] length,
  crypto_stream_unit_if.master mem,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] res_base_q, res_base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_data_out_q, mem_data_out_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] ks;
  logic              ks_load;
  logic              ks_advance;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] chain_mix;
  logic [ADDR_W-1:0] i_next;

`ifdef CRYPTO_CHAIN_EN
  logic [DATA_W-1:0] prev_q, prev_d;
  assign chain_mix = prev_q;
`else
  assign chain_mix = '0;
`endif

  assign i_next = i_q + ADDR_W'(1);

  crypto_keystream #(
    .DATA_W   (DATA_W),
    .LFSR_TAPS(LFSR_TAPS)
  ) u_keystream (
    .clk    (clk),
    .rst    (rst),
    .load   (ks_load),
    .advance(ks_advance),
    .seed   (key),
    .ks     (ks)
  );

  // Result of the current word, consumed only in CALC.
  always_comb begin
    if (mode_q == MODE_ENC) begin
      res = DATA_W'(rotl(rot_word_t'(din_q ^ ks ^ chain_mix), DATA_W, ROT));
    end else begin
      res = DATA_W'(rotr(rot_word_t'(din_q), DATA_W, ROT)) ^ ks ^ chain_mix;
    end
  end

  // Memory outputs are registered, so each is set on the edge that enters the
  // state using it: the READ address on entry to READ, write fields on entry
  // to WRITE. In other states mem_addr simply keeps its last value.
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    in_base_d      = in_base_q;
    res_base_d     = res_base_q;
    len_d          = len_q;
    i_d            = i_q;
    din_d          = din_q;
    mem_addr_d     = mem_addr_q;
    mem_write_d    = 1'b0;
    mem_data_out_d = mem_data_out_q;
    done_d         = (state_q == ST_FIN);
    ks_load        = 1'b0;
    ks_advance     = 1'b0;
`ifdef CRYPTO_CHAIN_EN
    prev_d         = prev_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d     = mode;
          in_base_d  = input_addr;
          res_base_d = result_addr;
          len_d      = length;
          i_d        = '0;
          ks_load    = 1'b1;
`ifdef CRYPTO_CHAIN_EN
          prev_d     = '0;
`endif
          if (length == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d    = ST_READ;
            mem_addr_d = input_addr;
          end
        end
      end
      ST_READ: begin
        din_d   = mem.mem_data_in;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        ks_advance     = 1'b1;
        mem_addr_d     = res_base_q + i_q;
        mem_write_d    = 1'b1;
        mem_data_out_d = res;
`ifdef CRYPTO_CHAIN_EN
        prev_d         = (mode_q == MODE_ENC) ? res : din_q;
`endif
        state_d        = ST_WRITE;
      end
      ST_WRITE: begin
        i_d = i_next;
        if (i_next == len_q) begin
          state_d = ST_FIN;
        end else begin
          state_d    = ST_READ;
          mem_addr_d = in_base_q + i_next;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      mode_q         <= 1'b0;
      in_base_q      <= '0;
      res_base_q     <= '0;
      len_q          <= '0;
      i_q            <= '0;
      din_q          <= '0;
      mem_addr_q     <= '0;
      mem_write_q    <= 1'b0;
      mem_data_out_q <= '0;
      done_q         <= 1'b0;
`ifdef CRYPTO_CHAIN_EN
      prev_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      in_base_q      <= in_base_d;
      res_base_q     <= res_base_d;
      len_q          <= len_d;
      i_q            <= i_d;
      din_q          <= din_d;
      mem_addr_q     <= mem_addr_d;
      mem_write_q    <= mem_write_d;
      mem_data_out_q <= mem_data_out_d;
      done_q         <= done_d;
`ifdef CRYPTO_CHAIN_EN
      prev_q         <= prev_d;
`endif
    end
  end

  assign mem.mem_addr     = mem_addr_q;
  assign mem.mem_write    = mem_write_q;
  assign mem.mem_data_out = mem_data_out_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;

endmodule

// File: tb/tb_crypto_stream_unit.sv
// -----------------------------------------------------------------------------
// tb_crypto_stream_unit
// Directed bench for crypto_stream_unit with a behavioural 1024-word memory.
// Hand-derived vectors (ROT=3, TAPS=19'h72000, key=1):
//   word0: din=19'h10000, ks=1       -> rotl3(19'h10001)            = 19'h00009
//   ks advance: ks=1 -> (0) ^ 19'h72000 = 19'h72000
//   word1: din=0,  ks=19'h72000      -> rotl3(19'h72000)            = 19'h10007
//   chained word1: din^ks^prev(9) = 19'h72009 -> rotl3              = 19'h1004F
// -----------------------------------------------------------------------------
module tb_crypto_stream_unit;

  localparam int DW = 19;
  localparam int AW = 10;

  localparam logic [DW-1:0] EXP0 = 19'h00009;
`ifdef CRYPTO_CHAIN_EN
  localparam logic [DW-1:0] EXP1 = 19'h1004F;
`else
  localparam logic [DW-1:0] EXP1 = 19'h10007;
`endif
  localparam logic [DW-1:0] SENTINEL = 19'h7FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] key = '0;
  logic [AW-1:0] input_addr = '0;
  logic [AW-1:0] result_addr = '0;
  logic [AW-1:0] length = '0;
  logic          busy;
  logic          done;

  crypto_stream_unit_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

  crypto_stream_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .key        (key),
    .input_addr (input_addr),
    .result_addr(result_addr),
    .length     (length),
    .mem        (mif),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write at posedge. The bench
  // preloads words through its own port while the DUT is idle.
  logic [DW-1:0] mem [0:1023];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_data = '0;
  int            write_cnt = 0;

  assign mif.mem_data_in = mem[mif.mem_addr];

  always @(posedge clk) begin
    if (mif.mem_write) begin
      mem[mif.mem_addr] <= mif.mem_data_out;
      write_cnt         <= write_cnt + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
  end

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    tb_addr = a;
    tb_data = d;
    tb_we   = 1'b1;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Starts a block and returns the number of edges after the start edge until
  // done is first seen (-1 on timeout) and the number of memory writes.
  task automatic run_block(input logic m, input logic [DW-1:0] k,
                           input logic [AW-1:0] ia, input logic [AW-1:0] ra,
                           input logic [AW-1:0] len,
                           output int cycles, output int writes);
    int w0;
    @(negedge clk);
    mode = m; key = k; input_addr = ia; result_addr = ra; length = len;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    w0 = write_cnt;
    cycles = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = c;
        break;
      end
    end
    writes = write_cnt - w0;
  endtask

  task automatic test_reset();
    #12;
    chk_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
    chk_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b expected 0", done); end
    chk_cnt++; if (mif.mem_write !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_write: got %b expected 0", mif.mem_write); end
    chk_cnt++; if (mif.mem_addr !== '0) begin err_cnt++; $display("FAIL reset_mem_addr: got %h expected 0", mif.mem_addr); end
    chk_cnt++; if (mif.mem_data_out !== '0) begin err_cnt++; $display("FAIL reset_mem_data_out: got %h expected 0", mif.mem_data_out); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_encrypt();
    int cyc, wr;
    poke(10'd0, 19'h10000);
    poke(10'd50, SENTINEL);
    run_block(1'b0, 19'd1, 10'd0, 10'd50, 10'd1, cyc, wr);
    chk_cnt++; if (cyc !== 4) begin err_cnt++; $display("FAIL single_latency: got %0d expected 4", cyc); end
    chk_cnt++; if (wr !== 1) begin err_cnt++; $display("FAIL single_writes: got %0d expected 1", wr); end
    chk_cnt++; if (mem[50] !== EXP0) begin err_cnt++; $display("FAIL single_result: got %h expected %h", mem[50], EXP0); end
    chk_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL single_busy_at_done: got %b expected 0", busy); end
    @(posedge clk);
    #1;
    chk_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL single_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_two_word();
    int cyc, wr;
    poke(10'd0, 19'h10000);
    poke(10'd1, 19'h00000);
    run_block(1'b0, 19'd1, 10'd0, 10'd60, 10'd2, cyc, wr);
    chk_cnt++; if (cyc !== 7) begin err_cnt++; $display("FAIL two_latency: got %0d expected 7", cyc); end
    chk_cnt++; if (wr !== 2) begin err_cnt++; $display("FAIL two_writes: got %0d expected 2", wr); end
    chk_cnt++; if (mem[60] !== EXP0) begin err_cnt++; $display("FAIL two_word0: got %h expected %h", mem[60], EXP0); end
    chk_cnt++; if (mem[61] !== EXP1) begin err_cnt++; $display("FAIL two_word1: got %h expected %h", mem[61], EXP1); end
  endtask

  task automatic test_round_trip();
    int cyc, wr;
    logic [DW-1:0] pt [7];
    pt = '{19'h10000, 19'h00000, 19'h10001, 19'h00011, 19'h10111, 19'h01111, 19'h00000};
    for (int j = 0; j < 7; j++) poke(AW'(j), pt[j]);
    run_block(1'b0, 19'h1ABCD, 10'd0, 10'd7, 10'd7, cyc, wr);
    chk_cnt++; if (cyc !== 22) begin err_cnt++; $display("FAIL rt_enc_latency: got %0d expected 22", cyc); end
    chk_cnt++; if (wr !== 7) begin err_cnt++; $display("FAIL rt_enc_writes: got %0d expected 7", wr); end
    run_block(1'b1, 19'h1ABCD, 10'd7, 10'd20, 10'd7, cyc, wr);
    for (int j = 0; j < 7; j++) begin
      chk_cnt++;
      if (mem[20+j] !== pt[j]) begin
        err_cnt++;
        $display("FAIL rt_word%0d: got %h expected %h", j, mem[20+j], pt[j]);
      end
    end
  endtask

  task automatic test_zero_length_key();
    int cyc, wr;
    run_block(1'b0, 19'd1, 10'd0, 10'd70, 10'd0, cyc, wr);
    chk_cnt++; if (cyc !== 1) begin err_cnt++; $display("FAIL zero_len_latency: got %0d expected 1", cyc); end
    chk_cnt++; if (wr !== 0) begin err_cnt++; $display("FAIL zero_len_writes: got %0d expected 0", wr); end
    poke(10'd0, 19'h10000);
    run_block(1'b0, 19'd0, 10'd0, 10'd71, 10'd1, cyc, wr);
    chk_cnt++; if (cyc !== 4) begin err_cnt++; $display("FAIL zero_key_latency: got %0d expected 4", cyc); end
    chk_cnt++; if (mem[71] !== EXP0) begin err_cnt++; $display("FAIL zero_key_result: got %h expected %h", mem[71], EXP0); end
  endtask

  task automatic test_busy_start();
    int cyc, wr;
    poke(10'd0, 19'h10000);
    poke(10'd1, 19'h00000);
    poke(10'd90, SENTINEL);
    fork
      run_block(1'b0, 19'd1, 10'd0, 10'd80, 10'd2, cyc, wr);
      begin
        @(negedge clk);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        start = 1'b1; mode = 1'b1; key = 19'h05555;
        input_addr = 10'd3; result_addr = 10'd90; length = 10'd5;
        @(posedge clk);
        #2 start = 1'b0;
      end
    join
    chk_cnt++; if (cyc !== 7) begin err_cnt++; $display("FAIL busy_latency: got %0d expected 7", cyc); end
    chk_cnt++; if (wr !== 2) begin err_cnt++; $display("FAIL busy_writes: got %0d expected 2", wr); end
    chk_cnt++; if (mem[80] !== EXP0) begin err_cnt++; $display("FAIL busy_word0: got %h expected %h", mem[80], EXP0); end
    chk_cnt++; if (mem[81] !== EXP1) begin err_cnt++; $display("FAIL busy_word1: got %h expected %h", mem[81], EXP1); end
    chk_cnt++; if (mem[90] !== SENTINEL) begin err_cnt++; $display("FAIL busy_no_second_block: got %h expected %h", mem[90], SENTINEL); end
  endtask

  task automatic test_wrap();
    int cyc, wr;
    poke(10'd1023, 19'h10000);
    poke(10'd0, 19'h00000);
    fork
      run_block(1'b0, 19'd1, 10'd1023, 10'd100, 10'd2, cyc, wr);
      begin
        @(negedge clk);
        @(posedge clk);
        #2;
        chk_cnt++; if (mif.mem_addr !== 10'd1023) begin err_cnt++; $display("FAIL wrap_read0_addr: got %0d expected 1023", mif.mem_addr); end
        repeat (3) @(posedge clk);
        #2;
        chk_cnt++; if (mif.mem_addr !== 10'd0) begin err_cnt++; $display("FAIL wrap_read1_addr: got %0d expected 0", mif.mem_addr); end
      end
    join
    chk_cnt++; if (mem[100] !== EXP0) begin err_cnt++; $display("FAIL wrap_word0: got %h expected %h", mem[100], EXP0); end
    chk_cnt++; if (mem[101] !== EXP1) begin err_cnt++; $display("FAIL wrap_word1: got %h expected %h", mem[101], EXP1); end
  endtask

  task automatic test_mid_reset();
    int cyc, wr, w0;
    poke(10'd0, 19'h10000);
    poke(10'd1, 19'h00000);
    poke(10'd2, 19'h10001);
    poke(10'd3, 19'h00011);
    for (int j = 110; j < 114; j++) poke(AW'(j), SENTINEL);
    @(negedge clk);
    mode = 1'b0; key = 19'd1; input_addr = 10'd0; result_addr = 10'd110;
    length = 10'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    w0 = write_cnt;
    repeat (4) @(posedge clk);    // now in CALC of the second word
    #1;
    chk_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    #1 rst = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    chk_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL midrst_done: got %b expected 0", done); end
    chk_cnt++; if (mif.mem_write !== 1'b0) begin err_cnt++; $display("FAIL midrst_mem_write: got %b expected 0", mif.mem_write); end
    chk_cnt++; if (mif.mem_addr !== '0) begin err_cnt++; $display("FAIL midrst_mem_addr: got %h expected 0", mif.mem_addr); end
    chk_cnt++; if (mif.mem_data_out !== '0) begin err_cnt++; $display("FAIL midrst_mem_data_out: got %h expected 0", mif.mem_data_out); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_cnt++; if (write_cnt - w0 !== 1) begin err_cnt++; $display("FAIL midrst_writes: got %0d expected 1", write_cnt - w0); end
    chk_cnt++; if (mem[110] !== EXP0) begin err_cnt++; $display("FAIL midrst_word0: got %h expected %h", mem[110], EXP0); end
    chk_cnt++; if (mem[111] !== SENTINEL) begin err_cnt++; $display("FAIL midrst_word1_untouched: got %h expected %h", mem[111], SENTINEL); end
    chk_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL midrst_idle_after: got %b expected 0", busy); end
    run_block(1'b0, 19'd1, 10'd0, 10'd120, 10'd1, cyc, wr);
    chk_cnt++; if (cyc !== 4) begin err_cnt++; $display("FAIL midrst_restart_latency: got %0d expected 4", cyc); end
    chk_cnt++; if (mem[120] !== EXP0) begin err_cnt++; $display("FAIL midrst_restart_result: got %h expected %h", mem[120], EXP0); end
  endtask

  initial begin
    test_reset();
    test_single_encrypt();
    test_two_word();
    test_round_trip();
    test_zero_length_key();
    test_busy_start();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
